// File: rtl/cpu_datapath_if.sv
// Control word, program-load port and observable outputs of the 8-bit bus datapath.
// The controller side is the master and the datapath is the slave.
interface cpu_datapath_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OPC_W  = 4;

  logic                count;
  logic                pc_output_enable;
  logic                load_mar;
  logic                output_enable_ram;
  logic                load_ir;
  logic                output_enable_ir;
  logic                load_a;
  logic                output_enable_a;
  logic                subtract_enable;
  logic                output_alu;
  logic                load_b;
  logic                write_enable_output;
  logic                load_immediate_a;
  logic                load_immediate_b;
  logic                store;
  logic                jump;

  logic                prog_we;
  logic [ADDR_W-1:0]   prog_addr;
  logic [DATA_W-1:0]   prog_data;

  logic [OPC_W-1:0]    instruction;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   out_value;
  logic                out_valid;
  logic                carry_flag;
  logic                zero_flag;
  logic                bus_conflict;

  modport master (
    output count, pc_output_enable, load_mar, output_enable_ram, load_ir,
           output_enable_ir, load_a, output_enable_a, subtract_enable, output_alu,
           load_b, write_enable_output, load_immediate_a, load_immediate_b, store, jump,
           prog_we, prog_addr, prog_data,
    input  instruction, bus, out_value, out_valid, carry_flag, zero_flag, bus_conflict
  );

  modport slave (
    input  count, pc_output_enable, load_mar, output_enable_ram, load_ir,
           output_enable_ir, load_a, output_enable_a, subtract_enable, output_alu,
           load_b, write_enable_output, load_immediate_a, load_immediate_b, store, jump,
           prog_we, prog_addr, prog_data,
    output instruction, bus, out_value, out_valid, carry_flag, zero_flag, bus_conflict
  );
endinterface

// File: rtl/cpu_datapath.sv
// Shared-bus execution datapath: PC, MAR, 16x8 RAM, IR, A/B, ALU and output register.
// Executes one control word per cycle and returns the opcode to the controller.
module cpu_datapath (
  input  logic           base_clk,
  input  logic           reset_ring,
  cpu_datapath_if.slave  dp
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned IMM_W  = 4;
  localparam int unsigned OE_W   = 3;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] ram_q [DEPTH];

  logic [DATA_W:0]   alu_sum_c;
  logic [DATA_W-1:0] imm_c, bus_c;
  logic [OE_W-1:0]   n_oe_c;

  // Subtraction is A + ~B + 1, so the carry out means "no borrow".
  always_comb begin
    alu_sum_c = {1'b0, a_q}
              + {1'b0, (dp.subtract_enable ? ~b_q : b_q)}
              + (DATA_W+1)'(dp.subtract_enable);
    imm_c     = {IMM_W'(0), ir_q[IMM_W-1:0]};
  end

  // Priority-muxed bus; forced to zero while reset holds off all control.
  always_comb begin
    bus_c = '0;
    if (!reset_ring) begin
      if (dp.output_enable_ram)     bus_c = ram_q[mar_q];
      else if (dp.output_alu)       bus_c = alu_sum_c[DATA_W-1:0];
      else if (dp.output_enable_a)  bus_c = a_q;
      else if (dp.output_enable_ir) bus_c = imm_c;
      else if (dp.pc_output_enable) bus_c = {IMM_W'(0), pc_q};
    end
  end

  assign n_oe_c = OE_W'(dp.output_enable_ram) + OE_W'(dp.output_alu)
                + OE_W'(dp.output_enable_a) + OE_W'(dp.output_enable_ir)
                + OE_W'(dp.pc_output_enable);

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    carry_d     = carry_q;
    zero_d      = zero_q;
    conflict_d  = conflict_q;
    if (!reset_ring) begin
      if (dp.jump)       pc_d = bus_c[ADDR_W-1:0];
      else if (dp.count) pc_d = pc_q + ADDR_W'(1);
      if (dp.load_mar)   mar_d = bus_c[ADDR_W-1:0];
      if (dp.load_ir)    ir_d  = bus_c;
      if (dp.load_immediate_a) a_d = imm_c;
      else if (dp.load_a)      a_d = bus_c;
      if (dp.load_immediate_b) b_d = imm_c;
      else if (dp.load_b)      b_d = bus_c;
      if (dp.write_enable_output) out_d = bus_c;
      out_valid_d = dp.write_enable_output;
      if (dp.output_alu && (dp.load_a || dp.load_b)) begin
        carry_d = alu_sum_c[DATA_W];
        zero_d  = (alu_sum_c[DATA_W-1:0] == '0);
      end
      conflict_d = conflict_q | (n_oe_c >= OE_W'(2));
    end
  end

  always_ff @(posedge base_clk) begin
    if (reset_ring) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      conflict_q  <= conflict_d;
    end
  end

  // RAM keeps its contents across reset; the load port is only live during reset.
  always_ff @(posedge base_clk) begin
    if (reset_ring) begin
      if (dp.prog_we) ram_q[dp.prog_addr] <= dp.prog_data;
    end else if (dp.store) begin
      ram_q[mar_q] <= a_q;
    end
  end

  assign dp.instruction  = ir_q[DATA_W-1:DATA_W-IMM_W];
  assign dp.bus          = bus_c;
  assign dp.out_value    = out_q;
  assign dp.out_valid    = out_valid_q;
  assign dp.carry_flag   = carry_q;
  assign dp.zero_flag    = zero_q;
  assign dp.bus_conflict = conflict_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed program scenarios followed by random control words,
// every cycle compared against an arithmetic reference model of the datapath.
module tb_cpu_datapath;
  localparam logic [15:0] W_CNT   = 16'h0001, W_PCOE = 16'h0002, W_LMAR = 16'h0004;
  localparam logic [15:0] W_RAMOE = 16'h0008, W_LIR  = 16'h0010, W_IROE = 16'h0020;
  localparam logic [15:0] W_LA    = 16'h0040, W_AOE  = 16'h0080, W_SUB  = 16'h0100;
  localparam logic [15:0] W_ALU   = 16'h0200, W_LB   = 16'h0400, W_WEO  = 16'h0800;
  localparam logic [15:0] W_LIA   = 16'h1000, W_LIB  = 16'h2000, W_STO  = 16'h4000;
  localparam logic [15:0] W_JMP   = 16'h8000;
  localparam logic [15:0] W_OES   = W_RAMOE | W_ALU | W_AOE | W_IROE | W_PCOE;

  logic base_clk = 1'b0;
  logic reset_ring;
  int   n_checks = 0;
  int   n_errors = 0;

  cpu_datapath_if dp();
  cpu_datapath dut (.base_clk(base_clk), .reset_ring(reset_ring), .dp(dp));

  always #5 base_clk = ~base_clk;

  // Reference state
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic       m_ov, m_c, m_z, m_conf;
  logic [7:0] m_ram [16];
  logic [7:0] prog [16];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void alu_ref(output logic [7:0] res, output logic cy);
    int sa, sb, r;
    sa = int'(m_a);
    sb = int'(m_b);
    if (dp.subtract_enable) begin
      r  = sa - sb;
      cy = (sa >= sb);
      if (r < 0) r = r + 256;
    end else begin
      r  = sa + sb;
      cy = (r > 255);
      r  = r % 256;
    end
    res = 8'(r);
  endfunction

  function automatic logic [7:0] model_bus();
    logic [7:0] res;
    logic       cy;
    alu_ref(res, cy);
    if (reset_ring)                return 8'h00;
    if (dp.output_enable_ram)      return m_ram[m_mar];
    if (dp.output_alu)             return res;
    if (dp.output_enable_a)        return m_a;
    if (dp.output_enable_ir)       return {4'h0, m_ir[3:0]};
    if (dp.pc_output_enable)       return {4'h0, m_pc};
    return 8'h00;
  endfunction

  task automatic check_outputs();
    check("instr",     {4'h0, dp.instruction}, {4'h0, m_ir[7:4]});
    check("bus",       dp.bus, model_bus());
    check("out_value", dp.out_value, m_out);
    check("out_valid", {7'h0, dp.out_valid}, {7'h0, m_ov});
    check("carry",     {7'h0, dp.carry_flag}, {7'h0, m_c});
    check("zero",      {7'h0, dp.zero_flag}, {7'h0, m_z});
    check("conflict",  {7'h0, dp.bus_conflict}, {7'h0, m_conf});
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare.
  task automatic step();
    logic [7:0] bv, res, o_a, o_ir;
    logic       cy;
    int         noe;
    bv   = model_bus();
    alu_ref(res, cy);
    o_a  = m_a;
    o_ir = m_ir;
    if (reset_ring) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_ov = 0; m_c = 0; m_z = 0; m_conf = 0;
      if (dp.prog_we) m_ram[dp.prog_addr] = dp.prog_data;
    end else begin
      noe = int'(dp.output_enable_ram) + int'(dp.output_alu) + int'(dp.output_enable_a)
          + int'(dp.output_enable_ir) + int'(dp.pc_output_enable);
      if (dp.jump)       m_pc = bv[3:0];
      else if (dp.count) m_pc = 4'((int'(m_pc) + 1) % 16);
      if (dp.store)      m_ram[m_mar] = o_a;
      if (dp.load_mar)   m_mar = bv[3:0];
      if (dp.load_ir)    m_ir = bv;
      if (dp.load_immediate_a) m_a = {4'h0, o_ir[3:0]};
      else if (dp.load_a)      m_a = bv;
      if (dp.load_immediate_b) m_b = {4'h0, o_ir[3:0]};
      else if (dp.load_b)      m_b = bv;
      if (dp.write_enable_output) m_out = bv;
      m_ov = dp.write_enable_output;
      if (dp.output_alu && (dp.load_a || dp.load_b)) begin
        m_c = cy;
        m_z = (res == 8'h00);
      end
      if (noe >= 2) m_conf = 1'b1;
    end
    @(posedge base_clk);
    #1;
    check_outputs();
  endtask

  task automatic drv(input logic [15:0] w);
    dp.count               = w[0];
    dp.pc_output_enable    = w[1];
    dp.load_mar            = w[2];
    dp.output_enable_ram   = w[3];
    dp.load_ir             = w[4];
    dp.output_enable_ir    = w[5];
    dp.load_a              = w[6];
    dp.output_enable_a     = w[7];
    dp.subtract_enable     = w[8];
    dp.output_alu          = w[9];
    dp.load_b              = w[10];
    dp.write_enable_output = w[11];
    dp.load_immediate_a    = w[12];
    dp.load_immediate_b    = w[13];
    dp.store               = w[14];
    dp.jump                = w[15];
  endtask

  task automatic run(input logic [15:0] w);
    drv(w);
    step();
  endtask

  task automatic expect_bus(input logic [15:0] w, input logic [7:0] exp, input string tag);
    drv(w);
    #1;
    check(tag, dp.bus, exp);
  endtask

  task automatic goto_pc(input logic [3:0] t);
    for (int i = 0; i < 16 && m_pc != t; i++) run(W_CNT);
  endtask

  task automatic set_mar(input logic [3:0] t);
    goto_pc(t);
    run(W_PCOE | W_LMAR);
  endtask

  task automatic ram_to(input logic [3:0] t, input logic [15:0] ld);
    set_mar(t);
    run(W_RAMOE | ld);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    int          r;
    prog = '{8'h0E, 8'hF0, 8'h20, 8'h05, 8'h37, 8'h73, 8'h2A, 8'hAA,
             8'h11, 8'h00, 8'h5A, 8'hC3, 8'h81, 8'h7F, 8'h1C, 8'hFF};
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_ov = 0; m_c = 0; m_z = 0; m_conf = 0;

    // Program load under reset, with junk control that must be ignored
    reset_ring = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dp.prog_we   = 1'b1;
      dp.prog_addr = 4'(i);
      dp.prog_data = prog[i];
      run(W_PCOE | W_LA | W_WEO | W_CNT);
    end
    dp.prog_we = 1'b0;
    check("rst_instr",     {4'h0, dp.instruction}, 8'h00);
    check("rst_bus",       dp.bus, 8'h00);
    check("rst_out_value", dp.out_value, 8'h00);
    check("rst_out_valid", {7'h0, dp.out_valid}, 8'h00);
    check("rst_flags",     {6'h0, dp.carry_flag, dp.zero_flag}, 8'h00);
    check("rst_conflict",  {7'h0, dp.bus_conflict}, 8'h00);
    reset_ring = 1'b0;

    // Fetch then LDA 14
    run(W_PCOE | W_LMAR);
    run(W_CNT);
    run(W_RAMOE | W_LIR);
    run(W_IROE | W_LMAR);
    run(W_RAMOE | W_LA);
    check("lda_instr", {4'h0, dp.instruction}, 8'h00);
    expect_bus(W_AOE, 8'h1C, "lda_a");
    expect_bus(W_PCOE, 8'h01, "lda_pc");

    // ADD F0 + 20 wraps with carry
    ram_to(4'd1, W_LA);
    ram_to(4'd2, W_LB);
    run(W_ALU | W_LA);
    check("add_carry", {7'h0, dp.carry_flag}, 8'h01);
    check("add_zero",  {7'h0, dp.zero_flag}, 8'h00);
    expect_bus(W_AOE, 8'h10, "add_a");

    // SUB 5 - 5: zero, no borrow
    ram_to(4'd3, W_LA);
    ram_to(4'd3, W_LB);
    run(W_SUB | W_ALU | W_LA);
    check("sub_carry", {7'h0, dp.carry_flag}, 8'h01);
    check("sub_zero",  {7'h0, dp.zero_flag}, 8'h01);
    expect_bus(W_AOE, 8'h00, "sub_a");

    // Immediate beats bus load, then store
    ram_to(4'd4, W_LIR);
    check("imm_instr", {4'h0, dp.instruction}, 8'h03);
    set_mar(4'd7);
    expect_bus(W_RAMOE | W_LA | W_LIA, 8'hAA, "lia_bus");
    run(W_RAMOE | W_LA | W_LIA);
    expect_bus(W_AOE, 8'h07, "lia_a");
    set_mar(4'd9);
    run(W_STO);
    expect_bus(W_RAMOE, 8'h07, "sta_ram");

    // PC wrap and jump overriding count
    goto_pc(4'd15);
    expect_bus(W_PCOE, 8'h0F, "pc15");
    run(W_CNT);
    expect_bus(W_PCOE, 8'h00, "pc_wrap");
    ram_to(4'd5, W_LIR);
    run(W_IROE | W_JMP | W_CNT);
    expect_bus(W_PCOE, 8'h03, "jump_pc");

    // OUT pulse
    ram_to(4'd6, W_LA);
    run(W_AOE | W_WEO);
    check("out_value", dp.out_value, 8'h2A);
    check("out_pulse", {7'h0, dp.out_valid}, 8'h01);
    run(16'h0000);
    check("out_drop",  {7'h0, dp.out_valid}, 8'h00);
    check("out_hold",  dp.out_value, 8'h2A);

    // Conflict: RAM wins, flag is sticky
    set_mar(4'd1);
    expect_bus(W_RAMOE | W_AOE, 8'hF0, "conf_bus");
    run(W_RAMOE | W_AOE);
    check("conf_set",    {7'h0, dp.bus_conflict}, 8'h01);
    run(16'h0000);
    check("conf_sticky", {7'h0, dp.bus_conflict}, 8'h01);

    // Reset mid-instruction; prog_we after release is ignored
    run(W_PCOE | W_LMAR);
    reset_ring = 1'b1;
    run(W_RAMOE | W_LIR);
    reset_ring   = 1'b0;
    dp.prog_we   = 1'b1;
    dp.prog_addr = 4'd1;
    dp.prog_data = 8'h55;
    run(16'h0000);
    dp.prog_we = 1'b0;
    check("mid_conflict", {7'h0, dp.bus_conflict}, 8'h00);
    check("mid_flags",    {6'h0, dp.carry_flag, dp.zero_flag}, 8'h00);
    check("mid_out",      dp.out_value, 8'h00);
    check("mid_instr",    {4'h0, dp.instruction}, 8'h00);
    expect_bus(W_AOE, 8'h00, "mid_a");
    expect_bus(W_PCOE, 8'h00, "mid_pc");
    set_mar(4'd1);
    expect_bus(W_RAMOE, 8'hF0, "mid_ram_kept");

    // Random control words, mostly single-driver, with occasional reset/program bursts
    for (int n = 0; n < 600; n++) begin
      w = 16'($urandom) & ~W_OES;
      r = $urandom_range(0, 19);
      if (r < 15) begin
        case (r % 5)
          0: w = w | W_RAMOE;
          1: w = w | W_ALU;
          2: w = w | W_AOE;
          3: w = w | W_IROE;
          default: w = w | W_PCOE;
        endcase
      end else if (r == 19) begin
        w = w | (16'($urandom) & W_OES);
      end
      reset_ring   = ($urandom_range(0, 39) == 0);
      dp.prog_we   = 1'($urandom);
      dp.prog_addr = 4'($urandom);
      dp.prog_data = 8'($urandom);
      run(w);
    end
    reset_ring = 1'b0;
    dp.prog_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Execution-side counterpart to `controller`. It receives the controller's control word each cycle and carries it out on an 8-bit shared bus. The bus links the PC, MAR, a 16×8 RAM, IR, the A/B registers, the ALU and the output register. It returns the current opcode (IR[7:4]) on `instruction` to close the fetch/decode loop. It also provides a program-load port so benches and top-level can fill RAM during reset.

## Interface
- Parameters: none; bus width 8, address width 4, RAM depth 16.
- `base_clk` in 1: sole clock, all state updates on rising edge.
- `reset_ring` in 1: synchronous, active-high reset; same line that resets the controller ring.
- `count, pc_output_enable, load_mar, output_enable_ram, load_ir, output_enable_ir, load_a, output_enable_a, subtract_enable, output_alu, load_b, write_enable_output, load_immediate_a, load_immediate_b, store, jump` in 1 each: control word, same names and meaning as `controller` outputs.
- `prog_we` in 1: RAM program-load write strobe; honoured only while `reset_ring`=1.
- `prog_addr` in 4: program-load address.
- `prog_data` in 8: program-load data.
- `instruction` out 4: IR[7:4], to controller.
- `bus` out 8: current bus value (observability).
- `out_value` out 8: output register.
- `out_valid` out 1: one-cycle pulse, cycle after an output-register load.
- `carry_flag, zero_flag` out 1: ALU flags.
- `bus_conflict` out 1: sticky, set if two or more drivers are enabled in one cycle.

## Operation
- Bus is combinational from the current enables and pre-edge register state.
- Driver priority: RAM[MAR] > ALU > A > {4'b0,IR[3:0]} > {4'b0,PC}.
- With no driver enabled, the bus is 8'h00.
- ALU: result = A + B, or A − B (two's complement, A + ~B + 1) when `subtract_enable`. Result is 8 bits; carry is the 9th bit (for SUB, carry=1 means no borrow).
- `count`: PC <= PC+1, wrapping 15→0.
- `jump`: PC <= bus[3:0]. `jump` overrides `count` in the same cycle.
- `load_mar`: MAR <= bus[3:0].
- `load_ir`: IR <= bus.
- `load_a`: A <= bus.
- `load_immediate_a`: A <= {4'b0,IR[3:0]}. Overrides `load_a`.
- `load_b`: B <= bus.
- `load_immediate_b`: B <= {4'b0,IR[3:0]}. Overrides `load_b`.
- `store`: RAM[MAR] <= A (pre-edge values).
- `write_enable_output`: out_value <= bus. `out_valid` is 1 for exactly the next cycle.
- Flags: update only in a cycle with `output_alu` && (`load_a` || `load_b`).
  - carry_flag <= ALU carry.
  - zero_flag <= (ALU result == 0).
  - Otherwise both hold.
- `bus_conflict`: set when the number of asserted output enables (`output_enable_ram`, `output_alu`, `output_enable_a`, `output_enable_ir`, `pc_output_enable`) is ≥2. Cleared only by reset.
- Reset:
  - Cleared to 0: PC, MAR, IR, A, B, out_value, out_valid, carry_flag, zero_flag, bus_conflict.
  - `instruction`=0, which decodes as LDA.
  - RAM is not cleared.
  - While reset is high, all control inputs except `prog_we` are ignored, and `bus` is 8'h00.
- Program load: `prog_we`=1 with `reset_ring`=1 gives RAM[prog_addr] <= prog_data. `prog_we` with `reset_ring`=0 is ignored.
- Reset mid-instruction: all registers clear next edge. The datapath keeps no partial-instruction state.

## Timing
- Single-edge design. Control word presented in cycle N takes effect at the rising edge ending cycle N.
- RAM read is asynchronous: RAM[MAR] is valid on the bus in the same cycle as `output_enable_ram`.
- Load paths have zero-cycle bus latency; register results are visible the cycle after the load.
- `instruction` changes the cycle after `load_ir`. The controller samples it on its next decode step.
- `out_valid`: asserted the cycle after `write_enable_output`. Consecutive writes keep it high continuously.
- Store then read same address: RAM[MAR] reflects the store from the next cycle.

## Test plan
- Program load + LDA:
  - Stimulus: under reset, write RAM[0]=8'h0E, RAM[14]=8'h1C. Release reset. Drive fetch (pc_oe+load_mar; count; ram_oe+load_ir), then LDA execute (ir_oe+load_mar; ram_oe+load_a).
  - Required: instruction=0, A=8'h1C, PC=1.
- ADD/SUB flags:
  - Stimulus: A=8'hF0, B=8'h20. Drive output_alu+load_a.
  - Required: A=8'h10, carry=1, zero=0.
  - Stimulus: then A=B=8'h05 with subtract_enable+output_alu+load_a.
  - Required: A=0, carry=1, zero=1.
- Immediates/STA:
  - Stimulus: IR=8'h37. Drive load_immediate_a together with load_a (bus=8'hAA).
  - Required: A=8'h07.
  - Stimulus: MAR=9, store.
  - Required: RAM[9]=8'h07, readable on the bus the next cycle.
- PC wrap/jump:
  - Stimulus: PC=15, count.
  - Required: PC=0.
  - Stimulus: IR=8'h73, ir_oe+jump+count.
  - Required: PC=3.
- OUT:
  - Stimulus: A=8'h2A, output_enable_a+write_enable_output.
  - Required: out_value=8'h2A, out_valid high one cycle only.
- Conflict/reset:
  - Stimulus: assert output_enable_ram and output_enable_a together.
  - Required: bus=RAM[MAR], bus_conflict=1 and sticky.
  - Stimulus: reset mid-sequence, with prog_we asserted after reset is released.
  - Required: all registers and flags return to 0, RAM contents preserved, the post-reset prog_we write ignored.
